// File: rtl/ges_pkg.sv
// rtl/ges_pkg.sv - shared types and constants for the gesture I2C arbiter
// Purpose: FSM state encoding, PAJ7620 device address, 50 MHz timing defaults
//          and a counter-width helper used by the arbiter.
// Ports:   none (package).
package ges_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } ges_state_t;

    localparam logic [7:0] PAJ7620_ADDR = 8'h73;

    // 20 ms watchdog and 5 us bus-free gap at 50 MHz
    localparam int DEF_TIMEOUT  = 1_000_000;
    localparam int DEF_BUS_FREE = 250;

    // Width of a counter that must hold 0..n-1; never narrower than 1 bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ges_rr_pick.sv
// rtl/ges_rr_pick.sv - combinational round-robin winner select
// Purpose: picks the first asserted request at an index above the last winner,
//          wrapping around; the last winner itself is considered last.
// Ports:   i_req  - request vector
//          i_last - index of the previous winner
//          o_win  - one-hot winner (all zero when no request)
module ges_rr_pick
    import ges_pkg::*;
#(
    parameter int NUM_REQ = 3,
    localparam int IW = cnt_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_last,
    output logic [NUM_REQ-1:0] o_win
);

    int w_idx;

    // Scan from the farthest offset down so the nearest request overwrites
    always_comb begin
        o_win = '0;
        w_idx = 0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            w_idx = (int'(i_last) + off) % NUM_REQ;
            if (i_req[w_idx]) begin
                o_win        = '0;
                o_win[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ges_i2c_arb.sv
// rtl/ges_i2c_arb.sv - arbiter sharing one I2C master between requesters
// Purpose: grants one requester at a time, issues one byte transaction to the
//          I2C master, watches for a hung master and enforces a bus-free gap.
// Ports:   i_sys_clk, i_sys_rst_n         - clock, async active-low reset
//          i_req, i_cmd_rw                - per-requester request / read flag
//          i_cmd_addr, i_cmd_wdata        - per-requester byte slices [8i+7:8i]
//          o_gnt, o_done, o_err           - one-hot grant, completion, timeout
//          o_rdata                        - last read byte
//          o_m_start/o_m_rw/o_m_addr/o_m_wdata - command to the I2C master
//          i_m_done, i_m_rdata            - completion and read byte from master
module ges_i2c_arb
    import ges_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int BUS_FREE = DEF_BUS_FREE,
    parameter bit PRIO0    = 1'b1
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_rst_n,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [NUM_REQ-1:0]     i_cmd_rw,
    input  logic [8*NUM_REQ-1:0]   i_cmd_addr,
    input  logic [8*NUM_REQ-1:0]   i_cmd_wdata,
    output logic [NUM_REQ-1:0]     o_gnt,
    output logic [NUM_REQ-1:0]     o_done,
    output logic [NUM_REQ-1:0]     o_err,
    output logic [7:0]             o_rdata,
    output logic                   o_m_start,
    output logic                   o_m_rw,
    output logic [7:0]             o_m_addr,
    output logic [7:0]             o_m_wdata,
    input  logic                   i_m_done,
    input  logic [7:0]             i_m_rdata
);

    localparam int IW = cnt_w(NUM_REQ);
    localparam int TW = cnt_w(TIMEOUT);
    localparam int BW = cnt_w(BUS_FREE);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [BW-1:0] GAP_LAST = BW'(BUS_FREE - 1);

    ges_state_t           r_state;
    logic [IW-1:0]        r_rr;
    logic [TW-1:0]        r_tmo_cnt;
    logic [BW-1:0]        r_gap_cnt;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_done;
    logic [NUM_REQ-1:0]   r_err;
    logic [7:0]           r_rdata;
    logic                 r_m_start;
    logic                 r_m_rw;
    logic [7:0]           r_m_addr;
    logic [7:0]           r_m_wdata;

    logic [NUM_REQ-1:0]   w_rr_win;
    logic [NUM_REQ-1:0]   w_win;
    logic [IW-1:0]        w_win_idx;

    ges_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req   (i_req),
        .i_last  (r_rr),
        .o_win   (w_rr_win)
    );

    // Requester 0 (boot-time config) may bypass round-robin entirely
    always_comb begin
        w_win = w_rr_win;
        if (PRIO0 && i_req[0]) begin
            w_win    = '0;
            w_win[0] = 1'b1;
        end
    end

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win[i]) begin
                w_win_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_state   <= ST_IDLE;
            r_rr      <= '0;
            r_tmo_cnt <= '0;
            r_gap_cnt <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_err     <= '0;
            r_rdata   <= '0;
            r_m_start <= 1'b0;
            r_m_rw    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
        end else begin
            // Pulses default low; each is raised for exactly one cycle below
            r_done    <= '0;
            r_err     <= '0;
            r_m_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|i_req) begin
                        r_state   <= ST_ISSUE;
                        r_gnt     <= w_win;
                        r_rr      <= w_win_idx;
                        r_m_start <= 1'b1;
                        r_m_rw    <= i_cmd_rw[w_win_idx];
                        r_m_addr  <= i_cmd_addr[{w_win_idx, 3'b000} +: 8];
                        r_m_wdata <= i_cmd_wdata[{w_win_idx, 3'b000} +: 8];
                    end
                end
                ST_ISSUE: begin
                    r_state   <= ST_WAIT;
                    r_tmo_cnt <= '0;
                end
                ST_WAIT: begin
                    // A completion on the final watchdog cycle still counts as done
                    if (i_m_done) begin
                        r_done    <= r_gnt;
                        if (r_m_rw) begin
                            r_rdata <= i_m_rdata;
                        end
                        r_gnt     <= '0;
                        r_gap_cnt <= '0;
                        r_state   <= ST_GAP;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_err     <= r_gnt;
                        r_gnt     <= '0;
                        r_gap_cnt <= '0;
                        r_state   <= ST_GAP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_gnt     = r_gnt;
    assign o_done    = r_done;
    assign o_err     = r_err;
    assign o_rdata   = r_rdata;
    assign o_m_start = r_m_start;
    assign o_m_rw    = r_m_rw;
    assign o_m_addr  = r_m_addr;
    assign o_m_wdata = r_m_wdata;

endmodule

// File: tb/tb_ges_i2c_arb.sv
// tb/tb_ges_i2c_arb.sv - self-checking bench for ges_i2c_arb
module tb_ges_i2c_arb;

    localparam int NR  = 3;
    localparam int TMO = 100;
    localparam int BF  = 250;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // index 0: round-robin instance, index 1: PRIO0 instance
    logic [NR-1:0]   req [2];
    logic [NR-1:0]   cmd_rw [2];
    logic [8*NR-1:0] cmd_addr [2];
    logic [8*NR-1:0] cmd_wdata [2];
    logic [NR-1:0]   gnt [2];
    logic [NR-1:0]   done [2];
    logic [NR-1:0]   err [2];
    logic [7:0]      rdata [2];
    logic            m_start [2];
    logic            m_rw [2];
    logic [7:0]      m_addr [2];
    logic [7:0]      m_wdata [2];
    logic            m_done [2];
    logic [7:0]      m_rdata [2];

    ges_i2c_arb #(.NUM_REQ(NR), .TIMEOUT(TMO), .BUS_FREE(BF), .PRIO0(1'b0)) u_dut_rr (
        .i_sys_clk(clk), .i_sys_rst_n(rst_n),
        .i_req(req[0]), .i_cmd_rw(cmd_rw[0]), .i_cmd_addr(cmd_addr[0]), .i_cmd_wdata(cmd_wdata[0]),
        .o_gnt(gnt[0]), .o_done(done[0]), .o_err(err[0]), .o_rdata(rdata[0]),
        .o_m_start(m_start[0]), .o_m_rw(m_rw[0]), .o_m_addr(m_addr[0]), .o_m_wdata(m_wdata[0]),
        .i_m_done(m_done[0]), .i_m_rdata(m_rdata[0])
    );

    ges_i2c_arb #(.NUM_REQ(NR), .TIMEOUT(TMO), .BUS_FREE(BF), .PRIO0(1'b1)) u_dut_p0 (
        .i_sys_clk(clk), .i_sys_rst_n(rst_n),
        .i_req(req[1]), .i_cmd_rw(cmd_rw[1]), .i_cmd_addr(cmd_addr[1]), .i_cmd_wdata(cmd_wdata[1]),
        .o_gnt(gnt[1]), .o_done(done[1]), .o_err(err[1]), .o_rdata(rdata[1]),
        .o_m_start(m_start[1]), .o_m_rw(m_rw[1]), .o_m_addr(m_addr[1]), .o_m_wdata(m_wdata[1]),
        .i_m_done(m_done[1]), .i_m_rdata(m_rdata[1])
    );

    typedef struct {
        int         d;
        int         k;
        bit         rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        bit         is_err;
        int         lat;
    } exp_t;

    typedef struct {
        int         d;
        int         k;
        bit         rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         delay;   // 0: master never answers
    } row_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         issue_t [2];
    logic [7:0] lastrd [2];
    int         mdelay [2];
    logic [7:0] mrd [2];
    int         mcnt [2];
    bit         mbusy [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // Sets up requester k's command and records the expected outcome
    task automatic stage(input int d, input int k, input bit rw, input logic [7:0] a,
                         input logic [7:0] w, input logic [7:0] rd, input int dly);
        exp_t e;
        cmd_rw[d][k]          = rw;
        cmd_addr[d][8*k +: 8]  = a;
        cmd_wdata[d][8*k +: 8] = w;
        e.d = d; e.k = k; e.rw = rw; e.addr = a; e.wdata = w;
        e.is_err = (dly == 0);
        e.lat    = (dly == 0) ? TMO + 1 : dly + 1;
        if (rw && dly != 0) lastrd[d] = rd;
        e.rdata = lastrd[d];
        sb.push_back(e);
    endtask

    task automatic wait_size(input int target, input string name);
        int n = 0;
        while (sb.size() > target && n < 2000) begin
            tick();
            n++;
        end
        check(name, sb.size(), target);
    endtask

    // I2C master model: answers D cycles after seeing m_start
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            m_done[d] = 1'b0;
            if (!rst_n) begin
                mbusy[d] = 1'b0;
            end else if (m_start[d]) begin
                mbusy[d] = 1'b1;
                mcnt[d]  = 0;
            end else if (mbusy[d]) begin
                mcnt[d]++;
                if (mdelay[d] != 0 && mcnt[d] == mdelay[d]) begin
                    m_done[d]  = 1'b1;
                    m_rdata[d] = mrd[d];
                    mbusy[d]   = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (m_start[d]) begin
                    if (sb.size() == 0 || sb[0].d != d) begin
                        check("unexpected m_start", 32'(m_start[d]), 0);
                    end else begin
                        check("issue gnt", gnt[d], 32'(1) << sb[0].k);
                        check("issue m_rw", 32'(m_rw[d]), 32'(sb[0].rw));
                        check("issue m_addr", m_addr[d], sb[0].addr);
                        check("issue m_wdata", m_wdata[d], sb[0].wdata);
                        issue_t[d] = cyc;
                    end
                end
                if (done[d] != 0 || err[d] != 0) begin
                    if (sb.size() == 0 || sb[0].d != d) begin
                        check("unexpected done/err", {done[d], err[d]}, 0);
                    end else begin
                        mon_e = sb.pop_front();
                        check("done vec", done[d], mon_e.is_err ? 0 : (32'(1) << mon_e.k));
                        check("err vec", err[d], mon_e.is_err ? (32'(1) << mon_e.k) : 0);
                        check("rdata", rdata[d], mon_e.rdata);
                        check("completion latency", cyc - issue_t[d], mon_e.lat);
                        check("gnt low in gap", gnt[d], 0);
                    end
                end
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        row_t tbl[8];
        int   g;
        tbl[0] = '{0, 1, 1'b0, 8'hEF, 8'h00, 8'h00, 40};
        tbl[1] = '{0, 1, 1'b1, 8'h43, 8'h00, 8'h04, 10};
        tbl[2] = '{0, 0, 1'b0, 8'h12, 8'h34, 8'h00, 3};
        tbl[3] = '{0, 2, 1'b1, 8'h55, 8'h00, 8'hA5, 1};
        tbl[4] = '{0, 2, 1'b0, 8'h60, 8'h9C, 8'h00, 0};
        tbl[5] = '{0, 2, 1'b1, 8'h61, 8'h00, 8'h77, TMO};
        tbl[6] = '{1, 2, 1'b0, 8'h73, 8'h5A, 8'h00, 7};
        tbl[7] = '{1, 0, 1'b1, 8'h02, 8'h00, 8'hC3, 2};

        for (int d = 0; d < 2; d++) begin
            req[d] = '0; cmd_rw[d] = '0; cmd_addr[d] = '0; cmd_wdata[d] = '0;
            m_rdata[d] = '0; mdelay[d] = 0; mrd[d] = '0; lastrd[d] = '0;
            issue_t[d] = 0; mcnt[d] = 0; mbusy[d] = 1'b0;
        end
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            check("reset gnt", gnt[d], 0);
            check("reset done/err", {done[d], err[d]}, 0);
            check("reset rdata", rdata[d], 0);
            check("reset m_start", 32'(m_start[d]), 0);
            check("reset m_cmd", {m_rw[d], m_addr[d], m_wdata[d]}, 0);
        end
        rst_n = 1'b1;
        tick();

        // Single transactions, one per row
        for (int i = 0; i < 8; i++) begin
            mdelay[tbl[i].d] = tbl[i].delay;
            mrd[tbl[i].d]    = tbl[i].rdata;
            stage(tbl[i].d, tbl[i].k, tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].delay);
            req[tbl[i].d][tbl[i].k] = 1'b1;
            tick();
            check("req to m_start latency", 32'(m_start[tbl[i].d]), 1);
            wait_size(0, "row completion");
            req[tbl[i].d][tbl[i].k] = 1'b0;
            repeat (BF + 3) tick();
        end
        check("rdata held after req drop", rdata[0], 8'h77);

        // Contention with round-robin: last winner was 2, so order is 0,1,2,0
        mdelay[0] = 5;
        stage(0, 0, 1'b0, 8'hA0, 8'h10, 8'h00, 5);
        stage(0, 1, 1'b0, 8'hA1, 8'h11, 8'h00, 5);
        stage(0, 2, 1'b0, 8'hA2, 8'h12, 8'h00, 5);
        stage(0, 0, 1'b0, 8'hA0, 8'h10, 8'h00, 5);
        req[0] = 3'b111;
        for (int n = 0; n < 4; n++) begin
            wait_size(3 - n, "rr completion");
            if (n == 3) begin
                req[0] = '0;
            end else begin
                g = 0;
                while (!m_start[0] && g < 1000) begin
                    g++;
                    tick();
                end
                check("rr gnt-low cycles between grants", g, BF + 1);
            end
        end
        repeat (BF + 10) tick();
        check("rr no grant after release", gnt[0], 0);

        // PRIO0: requester 0 wins while held, requester 1 after it drops
        mdelay[1] = 4;
        stage(1, 0, 1'b0, 8'hB0, 8'h20, 8'h00, 4);
        stage(1, 0, 1'b0, 8'hB0, 8'h20, 8'h00, 4);
        stage(1, 1, 1'b0, 8'hB1, 8'h21, 8'h00, 4);
        req[1] = 3'b011;
        wait_size(2, "prio first");
        wait_size(1, "prio second");
        req[1][0] = 1'b0;
        wait_size(0, "prio third");
        req[1] = '0;
        repeat (BF + 5) tick();

        // Reset while waiting on a hung master
        mdelay[0] = 0;
        stage(0, 1, 1'b1, 8'h10, 8'h00, 8'h00, 0);
        req[0] = 3'b010;
        repeat (20) tick();
        check("pre-reset gnt", gnt[0], 3'b010);
        #1 rst_n = 1'b0;
        #1;
        check("async reset gnt", gnt[0], 0);
        check("async reset m_start", 32'(m_start[0]), 0);
        check("async reset m_cmd", {m_rw[0], m_addr[0], m_wdata[0]}, 0);
        check("async reset rdata", rdata[0], 0);
        sb.delete();
        lastrd[0] = '0;
        lastrd[1] = '0;
        mdelay[0] = 6;
        mrd[0]    = 8'h3C;
        stage(0, 1, 1'b1, 8'h10, 8'h00, 8'h3C, 6);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("fresh m_start after reset", 32'(m_start[0]), 1);
        wait_size(0, "post-reset completion");
        req[0] = '0;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
